// File: rtl/digits_pkg.sv
// Shared glyph ROM geometry, converter state encoding and ROM addressing helper
// for the score digit renderer.
package digits_pkg;

   localparam int GLYPH_W    = 5;
   localparam int GLYPH_H    = 9;
   localparam int GLYPH_BITS = 45;
   localparam int ROM_AW     = 9;

   typedef enum logic [1:0] {
      CONV_IDLE,
      CONV_SHIFT,
      CONV_COMMIT
   } conv_state_t;

   // Glyphs are stored digit-major, then row-major: digit*45 + row*5 + col.
   function automatic logic [ROM_AW-1:0] glyph_addr(input logic [3:0] digit,
                                                    input logic [3:0] row,
                                                    input logic [2:0] col);
      return ROM_AW'(digit) * ROM_AW'(GLYPH_BITS)
           + ROM_AW'(row) * ROM_AW'(GLYPH_W)
           + ROM_AW'(col);
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one score bit per cycle, then a single
// COMMIT cycle where the result and overflow flag are presented with done.
module bin_to_bcd_seq
   import digits_pkg::*;
#(
   parameter int DIGITS  = 3,
   parameter int SCORE_W = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [SCORE_W-1:0]    value,
   output logic                  busy,
   output logic                  done,
   output logic [DIGITS*4-1:0]   bcd,
   output logic                  overflow
);

   localparam int BCD_W = DIGITS * 4;
   localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
   localparam int LIMIT = 10 ** DIGITS;

   conv_state_t          state;
   conv_state_t          state_next;
   logic                 load;
   logic [SCORE_W-1:0]   captured;
   logic [SCORE_W-1:0]   shreg;
   logic [BCD_W-1:0]     bcd_q;
   logic [BCD_W-1:0]     bcd_adj;
   logic [CNT_W-1:0]     cnt;

   always_comb begin
      state_next = state;
      load       = 1'b0;
      done       = 1'b0;
      busy       = (state != CONV_IDLE);
      case (state)
         CONV_IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = CONV_SHIFT;
            end
         end
         CONV_SHIFT: begin
            if (cnt == CNT_W'(SCORE_W - 1)) begin
               state_next = CONV_COMMIT;
            end
         end
         CONV_COMMIT: begin
            done = 1'b1;
            if (start) begin
               load       = 1'b1;
               state_next = CONV_SHIFT;
            end else begin
               state_next = CONV_IDLE;
            end
         end
         default: state_next = CONV_IDLE;
      endcase
   end

   // Nibbles that would reach 10 or more after the shift are pre-corrected by +3.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5) begin
            bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= CONV_IDLE;
         captured <= '0;
         shreg    <= '0;
         bcd_q    <= '0;
         cnt      <= '0;
      end else begin
         state <= state_next;
         if (load) begin
            captured <= value;
            shreg    <= value;
            bcd_q    <= '0;
            cnt      <= '0;
         end else if (state == CONV_SHIFT) begin
            bcd_q <= {bcd_adj[BCD_W-2:0], shreg[SCORE_W-1]};
            shreg <= shreg << 1;
            cnt   <= cnt + 1'b1;
         end
      end
   end

   assign bcd      = bcd_q;
   assign overflow = (32'(captured) >= 32'(LIMIT));

endmodule

// File: rtl/score_digits_renderer.sv
// Renders the current score from the 5x9 digit glyph ROM at a fixed position,
// through a two-stage pixel pipeline with leading-zero blanking.
module score_digits_renderer
   import digits_pkg::*;
#(
   parameter int DIGITS   = 3,
   parameter int SCORE_W  = 10,
   parameter int COORD_W  = 10,
   parameter int ORIGIN_X = 8,
   parameter int ORIGIN_Y = 8,
   parameter int SPACING  = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SCORE_W-1:0]  score,
   input  logic                score_valid,
   output logic                busy,
   input  logic [COORD_W-1:0]  x,
   input  logic [COORD_W-1:0]  y,
   input  logic                pixel_valid,
   output logic [ROM_AW-1:0]   rom_ad,
   input  logic                rom_dout,
   output logic                pixel_on,
   output logic                pixel_out_valid
);

   localparam int BCD_W      = DIGITS * 4;
   localparam int CELL_PITCH = GLYPH_W + SPACING;
   localparam int CW         = COORD_W + 1;

   logic                pending;
   logic [SCORE_W-1:0]  pending_value;
   logic                conv_start;
   logic [SCORE_W-1:0]  conv_value;
   logic                conv_done;
   logic [BCD_W-1:0]    conv_bcd;
   logic                conv_overflow;
   logic [BCD_W-1:0]    disp;

   logic [CW-1:0]       xe;
   logic [CW-1:0]       ye;
   logic                in_y;
   logic                lead;
   logic                hit;
   logic [3:0]          glyph_digit;
   logic [3:0]          row;
   logic [2:0]          col;
   logic                inside_q;
   logic                valid_q;

   // A strobe in the COMMIT cycle is consumed directly and wins over the pending value.
   assign conv_start = score_valid | pending;
   assign conv_value = score_valid ? score : pending_value;

   bin_to_bcd_seq #(
      .DIGITS  (DIGITS),
      .SCORE_W (SCORE_W)
   ) u_conv (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (conv_start),
      .value    (conv_value),
      .busy     (busy),
      .done     (conv_done),
      .bcd      (conv_bcd),
      .overflow (conv_overflow)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending       <= 1'b0;
         pending_value <= '0;
         disp          <= '0;
      end else begin
         if (conv_done) begin
            pending <= 1'b0;
         end else if (score_valid && busy) begin
            pending       <= 1'b1;
            pending_value <= score;
         end
         if (conv_done) begin
            disp <= conv_overflow ? {DIGITS{4'd9}} : conv_bcd;
         end
      end
   end

   assign xe   = {1'b0, x};
   assign ye   = {1'b0, y};
   assign in_y = (ye >= CW'(ORIGIN_Y)) && (ye < CW'(ORIGIN_Y + GLYPH_H));
   assign row  = 4'(ye - CW'(ORIGIN_Y));

   // Cell k = 0 is the most significant digit; lead tracks "all zero so far".
   always_comb begin
      hit         = 1'b0;
      glyph_digit = 4'd0;
      col         = 3'd0;
      lead        = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         lead = lead && (disp[(DIGITS-1-k)*4 +: 4] == 4'd0) && (k != DIGITS - 1);
         if (pixel_valid && in_y && !lead
             && (xe >= CW'(ORIGIN_X + k*CELL_PITCH))
             && (xe <  CW'(ORIGIN_X + k*CELL_PITCH + GLYPH_W))) begin
            hit         = 1'b1;
            glyph_digit = disp[(DIGITS-1-k)*4 +: 4];
            col         = 3'(xe - CW'(ORIGIN_X + k*CELL_PITCH));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_ad          <= '0;
         inside_q        <= 1'b0;
         valid_q         <= 1'b0;
         pixel_on        <= 1'b0;
         pixel_out_valid <= 1'b0;
      end else begin
         if (hit) begin
            rom_ad <= glyph_addr(glyph_digit, row, col);
         end
         inside_q        <= hit;
         valid_q         <= pixel_valid;
         pixel_on        <= inside_q & rom_dout;
         pixel_out_valid <= valid_q;
      end
   end

endmodule

// File: tb/tb_score_digits_renderer.sv
// Directed bench for score_digits_renderer with a behavioural glyph ROM model
// and hand-computed glyph addresses (origin 8,8, pitch 6, three digits).
module tb_score_digits_renderer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  score = '0;
   logic        score_valid = 1'b0;
   logic        busy;
   logic [9:0]  x = '0;
   logic [9:0]  y = '0;
   logic        pixel_valid = 1'b0;
   logic [8:0]  rom_ad;
   logic        rom_dout;
   logic        pixel_on;
   logic        pixel_out_valid;

   int total = 0;
   int bad   = 0;

   score_digits_renderer #(
      .DIGITS   (3),
      .SCORE_W  (10),
      .COORD_W  (10),
      .ORIGIN_X (8),
      .ORIGIN_Y (8),
      .SPACING  (1)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .score           (score),
      .score_valid     (score_valid),
      .busy            (busy),
      .x               (x),
      .y               (y),
      .pixel_valid     (pixel_valid),
      .rom_ad          (rom_ad),
      .rom_dout        (rom_dout),
      .pixel_on        (pixel_on),
      .pixel_out_valid (pixel_out_valid)
   );

   always #5 clk = ~clk;

   function automatic logic rom_model(input logic [8:0] a);
      return a[0] ^ a[2] ^ a[4] ^ (a[6] & a[1]) ^ (a[3] & a[5]);
   endfunction

   assign rom_dout = rom_model(rom_ad);

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Presents one pixel, checks rom_ad after one edge and pixel_on after two.
   task automatic apply_stimulus(input string tag, input int px, input int py,
                                 input bit exp_in, input int exp_addr);
      logic exp_on;
      x = 10'(px);
      y = 10'(py);
      pixel_valid = 1'b1;
      tick();
      check_output({tag, "_ad"}, 32'(rom_ad), 32'(exp_addr));
      pixel_valid = 1'b0;
      tick();
      exp_on = exp_in ? rom_model(9'(exp_addr)) : 1'b0;
      check_output({tag, "_on"}, 32'(pixel_on), 32'(exp_on));
      check_output({tag, "_ov"}, 32'(pixel_out_valid), 32'd1);
   endtask

   task automatic convert(input string tag, input int value);
      int cnt;
      score = 10'(value);
      score_valid = 1'b1;
      tick();
      score_valid = 1'b0;
      cnt = 0;
      while (busy && cnt < 100) begin
         cnt++;
         tick();
      end
      check_output({tag, "_busy_cycles"}, 32'(cnt), 32'd11);
   endtask

   initial begin
      int   cnt;
      bit   saw_42;
      bit   saw_busy;

      tick();
      tick();
      check_output("reset_busy", 32'(busy), 32'd0);
      check_output("reset_rom_ad", 32'(rom_ad), 32'd0);
      check_output("reset_pixel_on", 32'(pixel_on), 32'd0);
      check_output("reset_pov", 32'(pixel_out_valid), 32'd0);
      rst_n = 1'b1;
      tick();

      // Display "0": only cell 2 carries ink.
      apply_stimulus("zero_cell2_origin", 20, 8, 1'b1, 0);
      apply_stimulus("zero_cell2_r2c2", 22, 10, 1'b1, 12);
      apply_stimulus("zero_cell0_blank", 8, 8, 1'b0, 12);
      apply_stimulus("zero_spacing", 13, 8, 1'b0, 12);
      apply_stimulus("zero_below_row", 20, 17, 1'b0, 12);

      convert("s123", 123);
      apply_stimulus("s123_c0_r1", 8, 9, 1'b1, 50);
      apply_stimulus("s123_c1_r8c4", 18, 16, 1'b1, 134);
      apply_stimulus("s123_c2_org", 20, 8, 1'b1, 135);
      apply_stimulus("s123_right_edge", 25, 8, 1'b0, 135);

      convert("s7", 7);
      apply_stimulus("s7_c0_blank", 8, 8, 1'b0, 135);
      apply_stimulus("s7_c1_blank", 16, 12, 1'b0, 135);
      apply_stimulus("s7_c2_first", 20, 8, 1'b1, 315);
      apply_stimulus("s7_c2_last", 24, 16, 1'b1, 359);

      convert("s1023", 1023);
      apply_stimulus("sat_c0_first", 8, 8, 1'b1, 405);
      apply_stimulus("sat_c0_last", 12, 16, 1'b1, 449);
      apply_stimulus("sat_c2_first", 20, 8, 1'b1, 405);

      // Back-to-back strobes: 42 must be overwritten by 77 while pending.
      x = 10'd20;
      y = 10'd8;
      pixel_valid = 1'b1;
      saw_42 = 1'b0;
      score_valid = 1'b1;
      score = 10'd5;
      tick();
      score = 10'd42;
      tick();
      score = 10'd77;
      tick();
      score_valid = 1'b0;
      cnt = 3;
      while (busy && cnt < 100) begin
         if (rom_ad == 9'd90) saw_42 = 1'b1;
         tick();
         if (busy) cnt++;
         if (cnt == 13 && busy) check_output("pend_shows_5", 32'(rom_ad), 32'd225);
      end
      check_output("pend_busy_cycles", 32'(cnt), 32'd22);
      check_output("pend_no_42", 32'(saw_42), 32'd0);
      tick();
      check_output("pend_final_77", 32'(rom_ad), 32'd315);
      apply_stimulus("pend_c1_7", 14, 8, 1'b1, 315);
      apply_stimulus("pend_c0_blank", 8, 8, 1'b0, 315);

      // Reset in the middle of SHIFT with a load pending.
      x = 10'd20;
      y = 10'd8;
      pixel_valid = 1'b1;
      score = 10'd500;
      score_valid = 1'b1;
      tick();
      score_valid = 1'b0;
      tick();
      tick();
      score = 10'd321;
      score_valid = 1'b1;
      tick();
      score_valid = 1'b0;
      tick();
      check_output("rst_pre_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_rom_ad", 32'(rom_ad), 32'd0);
      check_output("rst_pixel_on", 32'(pixel_on), 32'd0);
      check_output("rst_pov", 32'(pixel_out_valid), 32'd0);
      tick();
      rst_n = 1'b1;
      saw_busy = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (busy) saw_busy = 1'b1;
      end
      check_output("rst_no_restart", 32'(saw_busy), 32'd0);
      apply_stimulus("rst_c1_blank", 14, 8, 1'b0, 0);
      apply_stimulus("rst_c2_zero", 22, 10, 1'b1, 12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/score_digits_renderer.md
# score_digits_renderer

Reads the 5×9 digit glyph ROM (`digits_image_rom`: 9-bit address in, 1-bit combinational pixel out) and draws the current score at a fixed screen position. It converts a binary score to BCD with a sequential double-dabble FSM. It maps the incoming pixel-scan coordinates to glyph ROM addresses and returns a registered per-pixel "score ink" flag to the frame compositor.

## Interface
Parameters:
- `DIGITS`, 3, number of displayed decimal digits (1..4)
- `SCORE_W`, 10, score width in bits
- `COORD_W`, 10, width of x/y coordinates
- `ORIGIN_X`, 8, left edge of the most significant digit cell
- `ORIGIN_Y`, 8, top edge of the digit row
- `SPACING`, 1, blank columns between digit cells

Ports:
- `clk` in 1, system clock
- `rst_n` in 1, reset, asynchronous assert, active-low
- `score` in SCORE_W, binary score value
- `score_valid` in 1, one-cycle load strobe for `score`
- `busy` out 1, conversion in progress
- `x`, `y` in COORD_W each, current scan pixel
- `pixel_valid` in 1, `x`/`y` are meaningful this cycle
- `rom_ad` out 9, registered address to `digits_image_rom.ad`
- `rom_dout` in 1, `digits_image_rom.dout`
- `pixel_on` out 1, score ink at the pixel presented two cycles earlier
- `pixel_out_valid` out 1, `pixel_valid` delayed two cycles

## Operation
- ROM layout (fixed): bit for digit d (0..9), row r (0..8), column c (0..4) is at address d*45 + r*5 + c. Addresses 450..511 are unused.
- Converter FSM states:
  - IDLE: on `score_valid`, capture `score`, clear the BCD shift register, go to SHIFT.
  - SHIFT: runs exactly SCORE_W cycles. Each cycle, add 3 to every nibble ≥5, then shift left with the next score MSB.
  - COMMIT: if the captured score ≥ 10^DIGITS, the displayed digits become all 9 (saturation). Otherwise they become the low DIGITS nibbles. Then go to IDLE, or back to SHIFT if a load is pending.
- `busy` = state != IDLE.
- `score_valid` while busy: overwrites a single pending register and sets the pending flag. Only the last value is kept. COMMIT consumes the pending value (captures it and clears the flag).
- Displayed digits change only in COMMIT, as one atomic update, so the display never tears.
- Leading-zero blanking: a digit renders as blank if it is 0 and every more significant digit is 0. The least significant digit is never blanked.
- Geometry:
  - Digit cell k (k=0 is most significant) spans x in [ORIGIN_X + k*(5+SPACING), +5) and y in [ORIGIN_Y, +9).
  - The cell index is found by parallel comparisons against constants. No dividers.
  - Pixels outside every cell, in spacing columns, or in blanked cells are "outside" and give `pixel_on` = 0.
- Arithmetic: c and r are computed as unsigned differences from the cell origin (3-bit and 4-bit). Comparisons use COORD_W+1 bits so an origin near the coordinate maximum cannot wrap.

## Timing
- Pipeline stage 1 (edge t): registers `rom_ad`, the inside flag and the valid flag, computed from `x`, `y` and `pixel_valid` sampled at t.
  - When the pixel is outside, `rom_ad` holds its previous value.
- Pipeline stage 2 (edge t+1): `pixel_on` <= inside & `rom_dout`; `pixel_out_valid` <= the stage-1 valid flag.
- Total latency is 2 cycles. Throughput is one pixel per cycle, with no stalls.
- A pixel with `pixel_valid` = 0 forces the inside flag to 0.
- Conversion: `busy` rises on the edge after `score_valid` and stays high for SCORE_W+1 cycles (SHIFT plus COMMIT). New digits render from the first pixel sampled after COMMIT.
- Reset values: `rom_ad` 0, `pixel_on` 0, `pixel_out_valid` 0, `busy` 0, FSM IDLE, pending flag 0, displayed digits all 0 (shows "0").
- Reset mid-conversion: returns to the reset values immediately, and the pending value is discarded.

## Structure
- Shared package `digits_pkg`:
  - Glyph constants: GLYPH_W=5, GLYPH_H=9, GLYPH_BITS=45, ROM_AW=9.
  - Function `glyph_addr(digit, row, col)`.
- Sub-module `bin_to_bcd_seq`: the double-dabble FSM, with a start/busy/done handshake and a DIGITS×4-bit result plus overflow flag.
- The top level holds the pending register, the displayed-digit register, blanking, geometry and the 2-stage pipeline.

## Test plan
- Reset then scan: with DIGITS=3, `pixel_on` is 0 everywhere except digit-0 ink in cell 2. At pixel (ORIGIN_X+12, ORIGIN_Y), `rom_ad` = 0 one cycle later.
- `score`=123, one-cycle strobe: `busy` is high for 11 cycles. Then pixel (ORIGIN_X, ORIGIN_Y+1) gives `rom_ad`=50, and pixel (ORIGIN_X+6+4, ORIGIN_Y+8) gives `rom_ad`=134. `pixel_on` equals the ROM bit 2 cycles after the pixel.
- `score`=7: cells 0 and 1 give `pixel_on`=0 for every pixel. Cell 2 reads addresses 315..359.
- `score`=1023 (DIGITS=3): display saturates to 999, so cell 0 addresses are 405..449.
- Strobes of 5, then 42, then 77 on consecutive cycles: one conversion of 5, then one of 77. The display never shows 42, and `busy` stays high continuously for 22 cycles.
- Assert `rst_n` low mid-SHIFT with a load pending: outputs are at reset values immediately. After release the display shows "0" and `busy`=0.
